load_store_unit: RTL
====================

# load_store_unit

Wishbone master that executes one CPU load or store per request against the data port of the combined instruction/data memory. It sits between the CPU's execute/memory stage and the memory's Wishbone slave port. It converts RISC-V byte/half/word accesses into word-addressed bus cycles with byte selects, and sign- or zero-extends load data. It also detects misaligned or illegal accesses and bounds every bus cycle with a timeout.

## Interface
- ADDR_WIDTH, 10, width of the byte address driven to the memory; matches $clog2 of the memory depth.
- TIMEOUT, 255, number of WAIT cycles without ack before the access is aborted with an error; at least 1.

- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  start an access; sampled only in IDLE.
- i_we  in  1  1 = store, 0 = load.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data, right-aligned.
- i_funct3  in  3  access type: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW.
- o_busy  out  1  high from the cycle after an accepted request until o_done.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  qualifies o_done; the access was misaligned, illegal or timed out.
- o_rdata  out  32  extended load result; valid with o_done on loads without error, held otherwise.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls.
- o_wb_addr  out  ADDR_WIDTH  {i_addr[ADDR_WIDTH-1:2], 2'b00}.
- o_wb_data  out  32  lane-replicated store data.
- o_wb_sel  out  4  byte-lane enables.
- i_wb_ack, i_wb_stall  in  1 each  slave handshake.
- i_wb_data  in  32  slave read data, valid with ack.

## Operation
- All outputs are registered. Reset values: every output 0, state IDLE, timeout counter 0.
- **IDLE**
  - When i_req=1, latch we, addr, wdata and funct3.
  - Legality check uses off = i_addr[1:0].
  - Illegal access: funct3 011, 110 or 111; store with funct3[2]=1; half access with off[0]=1; word access with off≠0.
  - Illegal → ERR. No bus activity occurs.
  - Legal → REQ with cyc=stb=1, and we/addr/data/sel driven.
- **REQ**
  - If i_wb_stall=1, hold stb and every bus output unchanged.
  - If i_wb_stall=0 and i_wb_ack=0 → WAIT with stb=0 and cyc=1.
  - If i_wb_stall=0 and i_wb_ack=1 in the same cycle → complete immediately, exactly as in WAIT.
- **WAIT**
  - On i_wb_ack: drop cyc, capture the load result, pulse o_done, return to IDLE.
  - Counter increments every WAIT cycle. When it reaches TIMEOUT without ack: drop cyc, pulse o_done with o_err=1, return to IDLE.
  - A late ack in IDLE is ignored.
- **ERR**: pulse o_done with o_err=1 for one cycle, then IDLE.
- Store steering:
  - SB: data = {4{wdata[7:0]}}, sel = 4'b0001 << off.
  - SH: data = {2{wdata[15:0]}}, sel = off[1] ? 4'b1100 : 4'b0011.
  - SW: data = wdata, sel = 4'b1111.
- Load steering:
  - sel uses the same lane patterns as stores.
  - Select the byte or half lane of i_wb_data at off.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- i_addr bits above ADDR_WIDTH-1 are ignored; the address is not range-checked.
- i_req while o_busy=1 is ignored; no queuing.
- o_busy=1 in REQ, WAIT and ERR.
- Asynchronous reset mid-access drops cyc/stb immediately and discards the access without an o_done.

## Timing
- Request accepted at edge 0; cyc/stb high during cycle 1.
- A zero-wait-state slave samples stb at edge 1 and acks during cycle 2.
- o_done/o_rdata are valid during cycle 3.
- Minimum latency is 3 cycles; each stall cycle and each ack wait cycle adds 1.
- Back-to-back: a new i_req is accepted during the o_done cycle, since the state is already IDLE.
- stb is high for exactly one accepted cycle per access. cyc covers REQ and WAIT.
- An error access gives o_done 2 cycles after request, with no cyc.
- Timeout gives o_done TIMEOUT+2 cycles after request, assuming no stall.

## Test plan
- **SW then LW:** SW addr 0x10, wdata 0xDEADBEEF, then LW addr 0x10 against the memory model. Expect sel 1111, o_rdata 0xDEADBEEF, each o_done 3 cycles after its request.
- **SB lanes:** SB 0x80 to addr 0x21 over word 0. Expect sel 0010 and wb_data 0x80808080. Then LB 0x21 → 0xFFFFFF80, LBU 0x21 → 0x00000080, LW 0x20 → 0x00008000.
- **SH upper half:** SH 0x1234 to addr 0x32 → sel 1100. LH 0x32 → 0x00001234.
- **Misaligned and illegal:** LW addr 0x02, SH addr 0x03, funct3 011. Expect o_done with o_err=1 two cycles after request, cyc never high, o_rdata unchanged.
- **Stall and timeout:** hold i_wb_stall for 3 cycles → stb held 4 cycles, then normal completion. With TIMEOUT=4 and ack suppressed → o_err after 4 WAIT cycles, cyc low. A late ack is then ignored.
- **Reset mid-access:** assert i_rst in WAIT → cyc/stb/o_busy go to 0 without waiting for a clock edge, no o_done. The next request completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Wishbone master executing one RISC-V load/store per request.
//            Steers byte/half/word accesses onto byte lanes, extends load
//            data, rejects illegal/misaligned accesses, bounds bus cycles.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [31:0]           i_addr,
    input  logic [31:0]           i_wdata,
    input  logic [2:0]            i_funct3,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [31:0]           o_rdata,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    output logic [ADDR_WIDTH-1:0] o_wb_addr,
    output logic [31:0]           o_wb_data,
    output logic [3:0]            o_wb_sel,
    input  logic                  i_wb_ack,
    input  logic                  i_wb_stall,
    input  logic [31:0]           i_wb_data
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [2:0]            r_funct3, w_funct3_nxt;
    logic [1:0]            r_off, w_off_nxt;
    logic                  r_busy, r_done, r_err;
    logic                  w_done_nxt, w_err_nxt;
    logic [31:0]           r_rdata, w_rdata_nxt;
    logic                  r_cyc, r_stb, r_we;
    logic                  w_cyc_nxt, w_stb_nxt, w_we_nxt;
    logic [ADDR_WIDTH-1:0] r_wb_addr, w_wb_addr_nxt;
    logic [31:0]           r_wb_data, w_wb_data_nxt;
    logic [3:0]            r_sel, w_sel_nxt;

    logic [1:0]            w_off;
    logic                  w_illegal;
    logic [3:0]            w_sel;
    logic [31:0]           w_store_data;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load_data;
    logic                  w_unused;

    // Address bits above the memory window carry no meaning here.
    assign w_unused = ^i_addr[31:ADDR_WIDTH];
    assign w_off    = i_addr[1:0];

    // Legality check and lane steering of the incoming request.
    always_comb begin
        w_illegal    = 1'b0;
        w_sel        = 4'b1111;
        w_store_data = i_wdata;
        case (i_funct3)
            3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
            default: w_illegal = (i_we && i_funct3[2])
                              || ((i_funct3[1:0] == 2'b01) && w_off[0])
                              || ((i_funct3[1:0] == 2'b10) && (w_off != 2'b00));
        endcase
        case (i_funct3[1:0])
            2'b00: begin
                w_sel        = 4'b0001 << w_off;
                w_store_data = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                w_sel        = w_off[1] ? 4'b1100 : 4'b0011;
                w_store_data = {2{i_wdata[15:0]}};
            end
            default: begin
                w_sel        = 4'b1111;
                w_store_data = i_wdata;
            end
        endcase
    end

    // Pick the addressed lane of the returned word and extend it.
    always_comb begin
        case (r_off)
            2'd0:    w_byte = i_wb_data[7:0];
            2'd1:    w_byte = i_wb_data[15:8];
            2'd2:    w_byte = i_wb_data[23:16];
            default: w_byte = i_wb_data[31:24];
        endcase
        w_half = r_off[1] ? i_wb_data[31:16] : i_wb_data[15:0];
        case (r_funct3[1:0])
            2'b00:   w_load_data = r_funct3[2] ? {24'd0, w_byte}
                                               : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_data = r_funct3[2] ? {16'd0, w_half}
                                               : {{16{w_half[15]}}, w_half};
            default: w_load_data = i_wb_data;
        endcase
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_funct3_nxt  = r_funct3;
        w_off_nxt     = r_off;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_rdata_nxt   = r_rdata;
        w_cyc_nxt     = r_cyc;
        w_stb_nxt     = r_stb;
        w_we_nxt      = r_we;
        w_wb_addr_nxt = r_wb_addr;
        w_wb_data_nxt = r_wb_data;
        w_sel_nxt     = r_sel;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (i_req) begin
                    w_funct3_nxt = i_funct3;
                    w_off_nxt    = w_off;
                    if (w_illegal) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_state_nxt   = S_REQ;
                        w_cyc_nxt     = 1'b1;
                        w_stb_nxt     = 1'b1;
                        w_we_nxt      = i_we;
                        w_wb_addr_nxt = {i_addr[ADDR_WIDTH-1:2], 2'b00};
                        w_wb_data_nxt = w_store_data;
                        w_sel_nxt     = w_sel;
                    end
                end
            end
            S_REQ: begin
                if (!i_wb_stall) begin
                    w_stb_nxt = 1'b0;
                    if (i_wb_ack) begin
                        w_state_nxt = S_IDLE;
                        w_cyc_nxt   = 1'b0;
                        w_done_nxt  = 1'b1;
                        if (!r_we) w_rdata_nxt = w_load_data;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            S_WAIT: begin
                if (i_wb_ack) begin
                    w_state_nxt = S_IDLE;
                    w_cyc_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    if (!r_we) w_rdata_nxt = w_load_data;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    // This WAIT cycle is the TIMEOUT-th without an ack.
                    w_state_nxt = S_IDLE;
                    w_cyc_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
                w_err_nxt   = 1'b1;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_funct3  <= 3'd0;
            r_off     <= 2'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= 32'd0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= 32'd0;
            r_sel     <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_funct3  <= w_funct3_nxt;
            r_off     <= w_off_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_rdata   <= w_rdata_nxt;
            r_cyc     <= w_cyc_nxt;
            r_stb     <= w_stb_nxt;
            r_we      <= w_we_nxt;
            r_wb_addr <= w_wb_addr_nxt;
            r_wb_data <= w_wb_data_nxt;
            r_sel     <= w_sel_nxt;
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_rdata   = r_rdata;
    assign o_wb_cyc  = r_cyc;
    assign o_wb_stb  = r_stb;
    assign o_wb_we   = r_we;
    assign o_wb_addr = r_wb_addr;
    assign o_wb_data = r_wb_data;
    assign o_wb_sel  = r_sel;

endmodule
`default_nettype wire
